// File: rtl/count_checker.sv
// count_checker: predicts and checks a counter's next value, with error statistics; optional sticky o_fail via COUNT_CHECKER_STICKY_EN
module count_checker #(
  parameter int COUNT_WD   = 16,
  parameter int ERR_CNT_WD = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_enable,
  input  logic                  i_clear,
  input  logic [COUNT_WD-1:0]   i_count,
  input  logic                  i_tm_reset,
  input  logic                  i_tm_direction,
  output logic                  o_locked,
  output logic                  o_mismatch,
  output logic [ERR_CNT_WD-1:0] o_err_count,
  output logic [COUNT_WD-1:0]   o_last_bad
`ifdef COUNT_CHECKER_STICKY_EN
  ,
  output logic                  o_fail
`endif
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SYNC  = 2'd1;
  localparam logic [1:0] TRACK = 2'd2;
  localparam logic [ERR_CNT_WD-1:0] ERR_MAX = '1;
  logic [1:0]          state, state_nxt;
  logic [COUNT_WD-1:0] pred, nxt;
  logic                bad;
  assign o_locked = (state == TRACK);
  // next-value model from the observed sample, next state, and the compare in TRACK
  always_comb begin
    nxt       = i_tm_reset ? '0 : i_tm_direction ? i_count + COUNT_WD'(1) : i_count - COUNT_WD'(1);
    state_nxt = !i_enable ? IDLE : (state == IDLE) ? SYNC : TRACK;
    bad       = (state == TRACK) && (i_count != pred);
  end
  // FSM, prediction reload and error statistics; clear beats a simultaneous mismatch
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      pred        <= '0;
      o_mismatch  <= 1'b0;
      o_err_count <= '0;
      o_last_bad  <= '0;
    end else begin
      state      <= state_nxt;
      if (state != IDLE) pred <= nxt;
      o_mismatch <= bad;
      if (i_clear) begin
        o_err_count <= '0;
        o_last_bad  <= '0;
      end else if (bad) begin
        o_err_count <= (o_err_count == ERR_MAX) ? o_err_count : o_err_count + ERR_CNT_WD'(1);
        o_last_bad  <= i_count;
      end
    end
  end
`ifdef COUNT_CHECKER_STICKY_EN
  // sticky fail flag, only reset clears it
  always_ff @(posedge i_clk) begin
    if (i_rst) o_fail <= 1'b0;
    else if (bad) o_fail <= 1'b1;
  end
`endif
endmodule
